// File: rtl/parking_pkg.sv
// Shared types and the next-state rule for the lot gate sensor FSM.
package parking_pkg;

    typedef enum logic [3:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_BA,
        OUT_A,
        CLEAR,
        FAULT
    } gate_state_t;

    localparam logic SENSOR_BLOCKED = 1'b1;

    // Sensor-driven next state from the filtered pair; unlisted pairs hold state.
    function automatic gate_state_t gate_next(input gate_state_t state,
                                              input logic        fa,
                                              input logic        fb);
        logic [1:0] pat;
        pat = {fa == SENSOR_BLOCKED, fb == SENSOR_BLOCKED};
        gate_next = state;
        case (state)
            IDLE: begin
                if (pat == 2'b10)      gate_next = IN_A;
                else if (pat == 2'b01) gate_next = OUT_B;
                else if (pat == 2'b11) gate_next = CLEAR;
            end
            IN_A: begin
                if (pat == 2'b11)      gate_next = IN_AB;
                else if (pat == 2'b00) gate_next = IDLE;
            end
            IN_AB: begin
                if (pat == 2'b01)      gate_next = IN_B;
                else if (pat == 2'b10) gate_next = IN_A;
            end
            IN_B: begin
                if (pat == 2'b00)      gate_next = IDLE;
                else if (pat == 2'b11) gate_next = IN_AB;
            end
            OUT_B: begin
                if (pat == 2'b11)      gate_next = OUT_BA;
                else if (pat == 2'b00) gate_next = IDLE;
            end
            OUT_BA: begin
                if (pat == 2'b10)      gate_next = OUT_A;
                else if (pat == 2'b01) gate_next = OUT_B;
            end
            OUT_A: begin
                if (pat == 2'b00)      gate_next = IDLE;
                else if (pat == 2'b11) gate_next = OUT_BA;
            end
            CLEAR: begin
                if (pat == 2'b00)      gate_next = IDLE;
            end
            FAULT: begin
                if (pat == 2'b00)      gate_next = IDLE;
            end
            default: gate_next = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a debounce counter for one beam sensor.
// The filtered level follows the synchronised input only after DEBOUNCE_CYCLES
// consecutive samples that disagree with the current level.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Synchronise the raw beam, then count a run of samples differing from the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gate_sensor_fsm.sv
// Lot gate passage tracker: debounces beams A (outer) and B (inner) and emits
// one-cycle car_in / car_out pulses for completed passages.
// Optional passage timeout and FAULT state enabled by defining GATE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no beam blocked, waiting for a car
// IN_A   | entering, outer beam only
// IN_AB  | entering, both beams
// IN_B   | entering, inner beam only
// OUT_B  | leaving, inner beam only
// OUT_BA | leaving, both beams
// OUT_A  | leaving, outer beam only
// CLEAR  | both beams blocked from idle, direction unknown
// FAULT  | passage stalled too long (GATE_TIMEOUT_EN only)
module gate_sensor_fsm
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic car_in,
    output logic car_out,
    output logic busy,
    output logic error
);

    logic        fa;
    logic        fb;
    gate_state_t state;
    gate_state_t nxt;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst   (rst),
        .raw   (sensor_a),
        .level (fa)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst   (rst),
        .raw   (sensor_b),
        .level (fb)
    );

`ifdef GATE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer;
    logic          passage;

    // Passage states are every state that is neither IDLE nor FAULT.
    always_comb passage = (state != IDLE) && (state != FAULT);

    // A sensor-driven move wins; a stalled passage at the limit falls into FAULT.
    always_comb begin
        nxt = gate_next(state, fa, fb);
        if (passage && (nxt == state) && (timer == TIMER_MAX)) begin
            nxt = FAULT;
        end
    end

    // Saturating dwell timer, cleared whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst || (nxt != state)) begin
            timer <= '0;
        end else if (passage && (timer != TIMER_MAX)) begin
            timer <= timer + TW'(1);
        end
    end
`else
    // Without the timeout, passages wait indefinitely for the sensors.
    always_comb nxt = gate_next(state, fa, fb);

    assign error = 1'b0;
`endif

    // State register with registered passage pulses (and fault flag when enabled).
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            car_in  <= 1'b0;
            car_out <= 1'b0;
`ifdef GATE_TIMEOUT_EN
            error   <= 1'b0;
`endif
        end else begin
            state   <= nxt;
            car_in  <= (state == IN_B)  && (nxt == IDLE);
            car_out <= (state == OUT_A) && (nxt == IDLE);
`ifdef GATE_TIMEOUT_EN
            error   <= (nxt == FAULT);
`endif
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_gate_sensor_fsm.sv
// Directed bench for gate_sensor_fsm with a pulse scoreboard.
// Works with and without GATE_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_gate_sensor_fsm;

    logic clk = 1'b0;
    logic rst;
    logic sensor_a;
    logic sensor_b;
    logic car_in;
    logic car_out;
    logic busy;
    logic error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit is_in;
        int cyc;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t got;

    gate_sensor_fsm #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .car_in   (car_in),
        .car_out  (car_out),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        step(n);
    endtask

    task automatic expect_pulse(input bit is_in, input int delay);
        pulse_t p;
        p.is_in = is_in;
        p.cyc   = cyc + delay;
        exp_q.push_back(p);
    endtask

    // Monitor: every pulse the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (car_in && car_out) begin
            checks++;
            errors++;
            $display("FAIL pulse_exclusive: car_in=1 and car_out=1 together (cycle %0d)", cyc);
        end else if (car_in || car_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: car_in=%0d car_out=%0d, expected none (cycle %0d)",
                         car_in, car_out, cyc);
            end else begin
                got = exp_q.pop_front();
                check("pulse_kind_is_in", 32'(car_in), 32'(got.is_in));
                check("pulse_cycle", cyc, got.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        step(3);
        check("reset_car_in",  32'(car_in),  0);
        check("reset_car_out", 32'(car_out), 0);
        check("reset_busy",    32'(busy),    0);
        check("reset_error",   32'(error),   0);
        rst = 1'b0;
        step(2);

        // 1: entry A, AB, B, 00 -> car_in 7 cycles after 00
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        check("t1_busy_in_b", 32'(busy), 1);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        expect_pulse(1'b1, 7);
        step(10);
        check("t1_busy_idle", 32'(busy), 0);
        check("t1_pending", exp_q.size(), 0);

        // 2: exit B, BA, A, 00 -> car_out; busy until the pulse cycle
        drive(1'b0, 1'b1, 10);
        check("t2_busy_out_b", 32'(busy), 1);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        expect_pulse(1'b0, 7);
        step(6);
        check("t2_busy_before_pulse", 32'(busy), 1);
        step(1);
        check("t2_busy_pulse_cycle", 32'(busy), 0);
        step(5);
        check("t2_pending", exp_q.size(), 0);

        // 3: reversal A, AB, A, 00 -> no pulse
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        check("t3_busy_in_ab", 32'(busy), 1);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        check("t3_busy_idle", 32'(busy), 0);
        check("t3_pending", exp_q.size(), 0);

        // 4: bounce on A every 2 cycles -> stays IDLE
        for (int i = 0; i < 10; i++) begin
            sensor_a = (i % 2 == 0);
            sensor_b = 1'b0;
            step(2);
            check("t4_busy_bounce", 32'(busy), 0);
        end
        drive(1'b0, 1'b0, 8);
        check("t4_busy_after", 32'(busy), 0);

        // 5: A held for 40 cycles
        drive(1'b1, 1'b0, 20);
        check("t5_error_early", 32'(error), 0);
        step(20);
        check("t5_busy_held", 32'(busy), 1);
`ifdef GATE_TIMEOUT_EN
        check("t5_error_fault", 32'(error), 1);
`else
        check("t5_error_tied", 32'(error), 0);
`endif
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        step(6);
`ifdef GATE_TIMEOUT_EN
        check("t5_error_before_release", 32'(error), 1);
`else
        check("t5_busy_before_release", 32'(busy), 1);
`endif
        step(1);
        check("t5_error_released", 32'(error), 0);
        check("t5_busy_released",  32'(busy),  0);
        step(5);
        check("t5_pending", exp_q.size(), 0);

        // 6: reset pulse while in IN_B
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        check("t6_busy_in_b", 32'(busy), 1);
        rst = 1'b1;
        step(1);
        check("t6_rst_busy",    32'(busy),    0);
        check("t6_rst_car_in",  32'(car_in),  0);
        check("t6_rst_car_out", 32'(car_out), 0);
        check("t6_rst_error",   32'(error),   0);
        rst = 1'b0;
        step(15);
        drive(1'b0, 1'b0, 15);
        check("t6_busy_idle", 32'(busy), 0);
        check("t6_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
